// File: rtl/carregador_instrucoes_pkg.sv
// Shared definitions for the boot-time instruction loader: FSM states,
// frame header byte and the address-width helper.
package carregador_instrucoes_pkg;

   typedef enum logic [2:0] {
      OCIOSO,
      TAMANHO,
      DADOS,
      CHECKSUM,
      PRONTO,
      ERRO
   } estado_t;

   localparam logic [7:0] CABECALHO = 8'hA5;

   // Number of address bits needed to index 'valor' words (valor >= 2).
   function automatic int clog2(input int valor);
      int largura;
      largura = 0;
      for (int i = 0; i < 31; i++) begin
         if ((1 << i) < valor) largura = i + 1;
      end
      return largura;
   endfunction

endpackage

// File: rtl/carregador_instrucoes.sv
// Boot-time loader: receives framed bytes (A5, N, N data bytes, XOR checksum),
// writes them into the instruction memory and keeps the CPU held until a frame
// with a matching checksum has been fully written.
module carregador_instrucoes
   import carregador_instrucoes_pkg::*;
#(
   parameter int PROFUNDIDADE = 16,
   parameter int LARGURA      = 8
) (
   input  logic                             clock,
   input  logic                             reset,
   input  logic [7:0]                       entrada_dado,
   input  logic                             entrada_valid,
   output logic                             entrada_ready,
   output logic                             escrita_en,
   output logic [clog2(PROFUNDIDADE)-1:0]   escrita_endereco,
   output logic [LARGURA-1:0]               escrita_dado,
   output logic                             cpu_hold,
   output logic                             carga_ok,
   output logic                             erro
);

   localparam int AW = clog2(PROFUNDIDADE);

   estado_t           estado_q;
   logic [8:0]        tamanho_q;
   logic [AW-1:0]     endereco_q;
   logic [7:0]        acumulador_q;

   logic              entrada_ready_q;
   logic              escrita_en_q;
   logic [AW-1:0]     escrita_endereco_q;
   logic [LARGURA-1:0] escrita_dado_q;
   logic              cpu_hold_q;
   logic              carga_ok_q;
   logic              erro_q;

   logic              aceito_d;
   logic              tamanho_invalido_d;
   logic              ultimo_byte_d;

   // Byte transfer and frame-field decodes used by the FSM.
   always_comb begin
      aceito_d           = entrada_valid && entrada_ready_q;
      // N is at most 255, so a 9-bit compare also covers PROFUNDIDADE = 256.
      tamanho_invalido_d = (entrada_dado == 8'd0) ||
                           ({1'b0, entrada_dado} > 9'(PROFUNDIDADE));
      ultimo_byte_d      = ((9'(endereco_q) + 9'd1) == tamanho_q);
   end

   // Frame FSM with the address counter, checksum accumulator and all
   // registered outputs.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         estado_q           <= OCIOSO;
         tamanho_q          <= '0;
         endereco_q         <= '0;
         acumulador_q       <= '0;
         entrada_ready_q    <= 1'b0;
         escrita_en_q       <= 1'b0;
         escrita_endereco_q <= '0;
         escrita_dado_q     <= '0;
         cpu_hold_q         <= 1'b1;
         carga_ok_q         <= 1'b0;
         erro_q             <= 1'b0;
      end else begin
         // The link is never throttled once out of reset.
         entrada_ready_q <= 1'b1;
         escrita_en_q    <= 1'b0;
         carga_ok_q      <= 1'b0;
         if (aceito_d) begin
            case (estado_q)
               OCIOSO: begin
                  if (entrada_dado == CABECALHO) estado_q <= TAMANHO;
               end
               TAMANHO: begin
                  if (tamanho_invalido_d) begin
                     estado_q   <= ERRO;
                     erro_q     <= 1'b1;
                     cpu_hold_q <= 1'b1;
                  end else begin
                     tamanho_q    <= 9'(entrada_dado);
                     endereco_q   <= '0;
                     acumulador_q <= '0;
                     estado_q     <= DADOS;
                  end
               end
               DADOS: begin
                  escrita_en_q       <= 1'b1;
                  escrita_endereco_q <= endereco_q;
                  escrita_dado_q     <= LARGURA'(entrada_dado);
                  acumulador_q       <= acumulador_q ^ entrada_dado;
                  // Counter stops on the last word so it can never wrap.
                  if (ultimo_byte_d) estado_q <= CHECKSUM;
                  else               endereco_q <= endereco_q + AW'(1);
               end
               CHECKSUM: begin
                  if (entrada_dado == acumulador_q) begin
                     estado_q   <= PRONTO;
                     carga_ok_q <= 1'b1;
                     cpu_hold_q <= 1'b0;
                  end else begin
                     estado_q   <= ERRO;
                     erro_q     <= 1'b1;
                     cpu_hold_q <= 1'b1;
                  end
               end
               PRONTO: begin
                  // A new header means reprogramming: hold the CPU again.
                  if (entrada_dado == CABECALHO) begin
                     estado_q   <= TAMANHO;
                     cpu_hold_q <= 1'b1;
                  end
               end
               ERRO: begin
                  if (entrada_dado == CABECALHO) begin
                     estado_q <= TAMANHO;
                     erro_q   <= 1'b0;
                  end
               end
               default: estado_q <= OCIOSO;
            endcase
         end
      end
   end

   assign entrada_ready    = entrada_ready_q;
   assign escrita_en       = escrita_en_q;
   assign escrita_endereco = escrita_endereco_q;
   assign escrita_dado     = escrita_dado_q;
   assign cpu_hold         = cpu_hold_q;
   assign carga_ok         = carga_ok_q;
   assign erro             = erro_q;

endmodule

// File: doc/carregador_instrucoes.md
# carregador_instrucoes

Boot-time loader that fills the processor's instruction memory over a byte-stream link (host/UART side) and holds the CPU until a complete, checksum-verified program is in place. It is the writing end of the instruction memory: it receives framed bytes and drives the memory's write port, while the fetch path reads the memory through the PC. It releases the CPU only after a valid frame.

## Interface
- PROFUNDIDADE, 16: instruction memory depth in words (2..256).
- LARGURA, 8: instruction width in bits.
- clock  in  1  system clock; all logic on rising edge.
- reset  in  1  asynchronous, active-high reset.
- entrada_dado  in  8  byte from host link.
- entrada_valid  in  1  byte on entrada_dado is valid this cycle.
- entrada_ready  out  1  loader can accept a byte; transfer occurs when valid && ready.
- escrita_en  out  1  instruction memory write strobe.
- escrita_endereco  out  clog2(PROFUNDIDADE)  write address.
- escrita_dado  out  LARGURA  write data.
- cpu_hold  out  1  high keeps the processor (PC) in reset.
- carga_ok  out  1  one-cycle pulse when a frame is verified.
- erro  out  1  level; last frame was rejected.

## Operation
- Frame: header 0xA5, length byte N, N instruction bytes, checksum byte = XOR of the N instruction bytes.
- States: OCIOSO, TAMANHO, DADOS, CHECKSUM, PRONTO, ERRO.
- OCIOSO: accepted byte 0xA5 -> TAMANHO; any other byte is consumed and ignored.
- TAMANHO: N==0 or N>PROFUNDIDADE -> ERRO; otherwise latch N, clear address counter and XOR accumulator -> DADOS.
- DADOS: each accepted byte written to address counter, XORed into accumulator, counter +1; after the Nth byte -> CHECKSUM.
- CHECKSUM: byte == accumulator -> PRONTO with carga_ok pulse; else -> ERRO.
- PRONTO: cpu_hold=0. Byte 0xA5 -> TAMANHO, cpu_hold=1 (reprogramming); other bytes ignored.
- ERRO: erro=1, cpu_hold=1. Byte 0xA5 -> TAMANHO and clears erro; other bytes ignored.
- erro is cleared on entry to TAMANHO, not on carga_ok.
- Memory contents beyond N-1 are untouched; words written before a checksum failure stay written, and the CPU stays held.
- Address counter never wraps: the length check bounds it to PROFUNDIDADE-1.

## Timing
- Reset values: entrada_ready=0, escrita_en=0, escrita_endereco=0, escrita_dado=0, cpu_hold=1, carga_ok=0, erro=0, state OCIOSO.
- entrada_ready=1 in every state from the first cycle after reset deasserts: one byte per cycle, no backpressure.
- All outputs registered. The write strobe, address and data appear the cycle after the DADOS byte handshake, for exactly one cycle.
- carga_ok is high and cpu_hold falls in the cycle after the checksum handshake.
- erro rises the cycle after the offending length or checksum handshake.
- Cycles with entrada_valid=0 leave state, counters and accumulator unchanged.
- Reset mid-frame aborts immediately: any pending write strobe is dropped and the next frame starts at address 0.

## Structure
- Shared package: state enum, CABECALHO = 8'hA5, address width function clog2(PROFUNDIDADE).
- Single module; the FSM, address counter and XOR accumulator are small enough that no sub-module is needed.

## Test plan
- A5 03 11 22 33 00 back-to-back -> writes 0:11, 1:22, 2:33; carga_ok one pulse; cpu_hold 1->0; erro=0.
- A5 02 0F F0 00 (correct checksum FF) -> writes 0:0F, 1:F0; erro=1, cpu_hold=1, no carga_ok. Then A5 01 7E 7E -> erro=0, carga_ok, cpu_hold=0.
- A5 00 -> erro=1 with no write. A5 11 with PROFUNDIDADE=16 -> erro=1 with no write.
- 00 FF 5A in OCIOSO, then A5 01 42 42 -> first three bytes produce no writes; then 0:42 and carga_ok.
- A5 04 01 02, reset pulse, A5 01 09 09 -> all outputs at reset values during reset; after it, write 0:09 and carga_ok.
- Frame from the first scenario with 0-3 idle cycles between bytes -> identical writes and pulse. After it, a new A5 in PRONTO -> cpu_hold back to 1 the cycle after.
